fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of an async FIFO among `NUM_REQ` requesters in the write clock domain. Each requester uses a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to `MAX_BURST` words, then drives `fifo_wr_en`/`fifo_wr_data` and respects the FIFO full flag. It sits between the write-side producers and the FIFO write interface.

---
 rtl/fifo_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of an async FIFO
// among NUM_REQ producers living in the write clock domain. One producer is
// granted at a time for a burst of up to MAX_BURST words. Writes are gated
// combinationally by the FIFO full flag, so no word is ever pushed into a
// full FIFO and no data is buffered inside this block.
//
// Ports:
//   wr_clk        write-domain clock (only clock in the block)
//   wr_rst_n      async-assert, sync-deassert active-low reset
//   req_valid     per-requester valid
//   req_data      per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-requester ready (only the grantee can be ready)
//   fifo_full     FIFO full flag, combinational from the FIFO
//   fifo_wr_en    FIFO write enable
//   fifo_wr_data  FIFO write data, zero when fifo_wr_en is low
//   grant_id      index of the current or most recent grantee
//   busy          high while a grant is active
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  // Wide enough to hold MAX_BURST itself.
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e           state_q,      state_d;
  logic [ID_W-1:0]  grant_id_q,   grant_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q,  burst_cnt_d;

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid bit strictly after 'last', wrapping modulo
  // NUM_REQ. 'last' itself is checked last, so a lone requester can be
  // re-granted. Result is {found, index}.
  // ---------------------------------------------------------------------------
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic            found;
    logic [ID_W-1:0] id;
    int              idx;
    found = 1'b0;
    id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
    return {found, id};
  endfunction

  logic [ID_W:0]         pick;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_id;

  assign pick       = rr_pick(req_valid, last_grant_q);
  assign pick_found = pick[ID_W];
  assign pick_id    = pick[ID_W-1:0];

  // ---------------------------------------------------------------------------
  // Grantee view of the request bus
  // ---------------------------------------------------------------------------
  logic                  in_grant;
  logic                  g_valid;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  xfer;
  logic                  last_beat;

  assign in_grant  = (state_q == ST_GRANT);
  assign g_valid   = req_valid[grant_id_q];
  assign g_data    = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
  // fifo_full gates the write in the same cycle it rises; no wait for a clock.
  assign xfer      = in_grant && g_valid && !fifo_full;
  assign last_beat = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  // ---------------------------------------------------------------------------
  // Write-port and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default on
    // entry; any path that leaves one unassigned would infer a latch.
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (in_grant) begin
      req_ready[grant_id_q] = !fifo_full;
    end
    if (xfer) begin
      fifo_wr_en   = 1'b1;
      fifo_wr_data = g_data;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = in_grant;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
          state_d     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!g_valid) begin
          // Grantee went away: give the port up without writing.
          state_d      = ST_IDLE;
          last_grant_d = grant_id_q;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_id_q;
          end
        end
        // Valid but full: hold the grant with the count frozen, indefinitely.
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. last_grant resets to NUM_REQ-1 so that requester 0 is
  // first in line after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, 8-bit data).
// Each requester offers lim[i] words, base[i]+0, base[i]+1, ..., advancing
// only when its word is accepted. Expected per-cycle responses are written
// out by hand in each test task.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic             wr_clk = 1'b0;
  logic             wr_rst_n = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic [IDW-1:0]   grant_id;
  logic             busy;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .wr_clk       (wr_clk),
    .wr_rst_n     (wr_rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester state
  int        cnt  [NR];
  int        lim  [NR];
  logic [7:0] base [NR];

  // Outputs sampled mid-cycle
  logic [NR-1:0]  o_ready;
  logic           o_wen;
  logic [DW-1:0]  o_wdata;
  logic [IDW-1:0] o_gid;
  logic           o_busy;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = (cnt[i] < lim[i]);
      req_data[i*DW +: DW]   = base[i] + 8'(cnt[i]);
    end
  endtask

  // One clock cycle: drive, sample on the falling edge, advance accepted
  // requesters, then move to just after the rising edge.
  task automatic step();
    drive();
    @(negedge wr_clk);
    o_ready = req_ready;
    o_wen   = fifo_wr_en;
    o_wdata = fifo_wr_data;
    o_gid   = grant_id;
    o_busy  = busy;
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) cnt[i]++;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_rst_n  = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      cnt[i]  = 0;
      lim[i]  = 0;
      base[i] = 8'h00;
    end
    drive();
    repeat (2) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    wr_rst_n = 1'b0;
    lim[0] = 2; base[0] = 8'h33;
    drive();
    #3;
    n_checks++;
    if ({req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b wr_en=%b data=%h gid=%0d busy=%b, required all 0",
               req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy);
    end
    n_checks++;
    if (dut.last_grant_q !== 2'd3) begin
      n_fail++;
      $display("FAIL reset_last_grant: got %0d required 3", dut.last_grant_q);
    end
    @(posedge wr_clk); #1;
    wr_rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_requester();
    int e_wen  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    int e_data [10] = '{0, 'h10, 'h11, 'h12, 'h13, 0, 'h14, 'h15, 0, 0};
    int e_busy [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    do_reset();
    lim[0] = 6; base[0] = 8'h10;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (o_wen !== 1'(e_wen[c])) begin
        n_fail++;
        $display("FAIL single_wr_en c%0d: got %b required %0d", c, o_wen, e_wen[c]);
      end
      n_checks++;
      if (o_wdata !== 8'(e_data[c])) begin
        n_fail++;
        $display("FAIL single_wr_data c%0d: got %h required %h", c, o_wdata, 8'(e_data[c]));
      end
      n_checks++;
      if (o_busy !== 1'(e_busy[c])) begin
        n_fail++;
        $display("FAIL single_busy c%0d: got %b required %0d", c, o_busy, e_busy[c]);
      end
      n_checks++;
      if (o_gid !== 2'd0) begin
        n_fail++;
        $display("FAIL single_grant_id c%0d: got %0d required 0", c, o_gid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_all_valid_round_robin();
    int writes;
    int ph, j, g;
    logic [7:0]    exp_data;
    logic [NR-1:0] exp_ready;
    do_reset();
    base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;
    for (int i = 0; i < NR; i++) lim[i] = 8;
    writes = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      ph = k % 5;
      j  = k / 5;
      g  = j % 4;
      exp_ready = (ph != 0) ? NR'(1 << g) : '0;
      exp_data  = (ph != 0) ? base[g] + 8'(4 * (j / 4) + ph - 1) : 8'h00;
      if (o_wen) writes++;
      n_checks++;
      if (o_wen !== (ph != 0)) begin
        n_fail++;
        $display("FAIL rr_wr_en k%0d: got %b required %b", k, o_wen, (ph != 0));
      end
      n_checks++;
      if (o_wdata !== exp_data) begin
        n_fail++;
        $display("FAIL rr_wr_data k%0d: got %h required %h", k, o_wdata, exp_data);
      end
      n_checks++;
      if (o_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rr_ready k%0d: got %b required %b", k, o_ready, exp_ready);
      end
      if (ph != 0) begin
        n_checks++;
        if (o_gid !== 2'(g)) begin
          n_fail++;
          $display("FAIL rr_grant_id k%0d: got %0d required %0d", k, o_gid, g);
        end
      end
    end
    n_checks++;
    if (writes != 20) begin
      n_fail++;
      $display("FAIL rr_write_count: got %0d required 20", writes);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full_mid_burst();
    int e_wen  [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    int e_data [9] = '{0, 'h50, 'h51, 0, 0, 0, 'h52, 'h53, 0};
    int e_busy [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    do_reset();
    lim[1] = 4; base[1] = 8'h50;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      step();
      n_checks++;
      if (o_wen !== 1'(e_wen[c])) begin
        n_fail++;
        $display("FAIL full_wr_en c%0d: got %b required %0d", c, o_wen, e_wen[c]);
      end
      n_checks++;
      if (o_ready[1] !== 1'(e_wen[c])) begin
        n_fail++;
        $display("FAIL full_ready1 c%0d: got %b required %0d", c, o_ready[1], e_wen[c]);
      end
      n_checks++;
      if (o_wdata !== 8'(e_data[c])) begin
        n_fail++;
        $display("FAIL full_wr_data c%0d: got %h required %h", c, o_wdata, 8'(e_data[c]));
      end
      n_checks++;
      if (o_busy !== 1'(e_busy[c])) begin
        n_fail++;
        $display("FAIL full_busy c%0d: got %b required %0d", c, o_busy, e_busy[c]);
      end
      if (c >= 1 && c <= 7) begin
        n_checks++;
        if (o_gid !== 2'd1) begin
          n_fail++;
          $display("FAIL full_grant_id c%0d: got %0d required 1", c, o_gid);
        end
      end
    end
    fifo_full = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_early_drop();
    int e_wen  [10] = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    int e_data [10] = '{0, 'h60, 'h61, 0, 0, 'h70, 'h71, 'h72, 0, 0};
    int e_busy [10] = '{0, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    lim[2] = 2; base[2] = 8'h60;
    lim[3] = 3; base[3] = 8'h70;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (o_wen !== 1'(e_wen[c])) begin
        n_fail++;
        $display("FAIL drop_wr_en c%0d: got %b required %0d", c, o_wen, e_wen[c]);
      end
      n_checks++;
      if (o_wdata !== 8'(e_data[c])) begin
        n_fail++;
        $display("FAIL drop_wr_data c%0d: got %h required %h", c, o_wdata, 8'(e_data[c]));
      end
      n_checks++;
      if (o_busy !== 1'(e_busy[c])) begin
        n_fail++;
        $display("FAIL drop_busy c%0d: got %b required %0d", c, o_busy, e_busy[c]);
      end
      if (c == 1 || c == 2) begin
        n_checks++;
        if (o_gid !== 2'd2) begin
          n_fail++;
          $display("FAIL drop_grant_id c%0d: got %0d required 2", c, o_gid);
        end
      end
      if (c >= 5 && c <= 7) begin
        n_checks++;
        if (o_gid !== 2'd3) begin
          n_fail++;
          $display("FAIL drop_grant_id c%0d: got %0d required 3", c, o_gid);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (dut.last_grant_q !== 2'd2) begin
          n_fail++;
          $display("FAIL drop_last_grant: got %0d required 2", dut.last_grant_q);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap_priority();
    int e_wen  [7] = '{0, 1, 0, 0, 1, 0, 0};
    int e_data [7] = '{0, 'h80, 0, 0, 'h90, 0, 0};
    int e_busy [7] = '{0, 1, 1, 0, 1, 1, 0};
    do_reset();
    lim[0] = 1; base[0] = 8'h80;
    lim[2] = 1; base[2] = 8'h90;
    for (int c = 0; c < 7; c++) begin
      step();
      n_checks++;
      if (o_wen !== 1'(e_wen[c])) begin
        n_fail++;
        $display("FAIL wrap_wr_en c%0d: got %b required %0d", c, o_wen, e_wen[c]);
      end
      n_checks++;
      if (o_wdata !== 8'(e_data[c])) begin
        n_fail++;
        $display("FAIL wrap_wr_data c%0d: got %h required %h", c, o_wdata, 8'(e_data[c]));
      end
      n_checks++;
      if (o_busy !== 1'(e_busy[c])) begin
        n_fail++;
        $display("FAIL wrap_busy c%0d: got %b required %0d", c, o_busy, e_busy[c]);
      end
      if (c == 1 || c == 4) begin
        n_checks++;
        if (o_gid !== ((c == 1) ? 2'd0 : 2'd2)) begin
          n_fail++;
          $display("FAIL wrap_grant_id c%0d: got %0d required %0d", c, o_gid, (c == 1) ? 0 : 2);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_burst();
    do_reset();
    base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;
    for (int i = 0; i < NR; i++) lim[i] = 8;
    repeat (3) step();
    drive();
    #1;
    n_checks++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hA2) begin
      n_fail++;
      $display("FAIL rstmid_pre_write: wr_en=%b data=%h required 1 a2", fifo_wr_en, fifo_wr_data);
    end
    #1;
    wr_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: ready=%b wr_en=%b data=%h gid=%0d busy=%b, required all 0",
               req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy);
    end
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    drive();
    @(posedge wr_clk); #1;
    wr_rst_n = 1'b1;
    step();
    n_checks++;
    if (o_wen !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: wr_en=%b busy=%b required 0 0", o_wen, o_busy);
    end
    step();
    n_checks++;
    if (o_wen !== 1'b1 || o_gid !== 2'd0 || o_wdata !== 8'hA0 || o_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_first_grant: wr_en=%b gid=%0d data=%h ready=%b required 1 0 a0 0001",
               o_wen, o_gid, o_wdata, o_ready);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single_requester();
    test_all_valid_round_robin();
    test_full_mid_burst();
    test_early_drop();
    test_wrap_priority();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
